// File: rtl/alarm_pkg.sv
// Shared alarm definitions: state encoding and time-field widths, also used by
// the display multiplexer to show alarm status.
package alarm_pkg;

    localparam int HR_W  = 5;
    localparam int MIN_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } alarm_state_e;

    // Width of a counter that must hold 0..limit, never narrower than 1 bit.
    function automatic int cnt_w(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/buzz_pattern_gen.sv
// Buzzer tone/cadence generator. While en is high it plays tone bursts
// (on-phase) alternating with silence (off-phase); a rising en restarts at phase 0.
module buzz_pattern_gen
    import alarm_pkg::*;
#(
    parameter int TONE_DIV    = 25_000,
    parameter int CADENCE_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic buzz
);

    localparam int TW = cnt_w(TONE_DIV);
    localparam int CW = cnt_w(CADENCE_DIV);
    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);
    localparam logic [CW-1:0] CAD_LAST  = CW'(CADENCE_DIV - 1);

    logic [TW-1:0] tone_cnt_q, tone_cnt_d;
    logic [CW-1:0] cad_cnt_q,  cad_cnt_d;
    logic          off_phase_q, off_phase_d;
    logic          active_q,    active_d;
    logic          buzz_q,      buzz_d;

    always_comb begin
        tone_cnt_d  = tone_cnt_q;
        cad_cnt_d   = cad_cnt_q;
        off_phase_d = off_phase_q;
        active_d    = active_q;
        buzz_d      = buzz_q;

        if (!en) begin
            tone_cnt_d  = '0;
            cad_cnt_d   = '0;
            off_phase_d = 1'b0;
            active_d    = 1'b0;
            buzz_d      = 1'b0;
        end else if (!active_q) begin
            // First enabled cycle: tone is already high so buzz is 1 on entry.
            tone_cnt_d  = '0;
            cad_cnt_d   = '0;
            off_phase_d = 1'b0;
            active_d    = 1'b1;
            buzz_d      = 1'b1;
        end else if (cad_cnt_q == CAD_LAST) begin
            cad_cnt_d   = '0;
            tone_cnt_d  = '0;
            off_phase_d = !off_phase_q;
            buzz_d      = off_phase_q;
        end else begin
            cad_cnt_d = cad_cnt_q + 1'b1;
            if (tone_cnt_q == TONE_LAST) begin
                tone_cnt_d = '0;
                buzz_d     = off_phase_q ? 1'b0 : !buzz_q;
            end else begin
                tone_cnt_d = tone_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tone_cnt_q  <= '0;
            cad_cnt_q   <= '0;
            off_phase_q <= 1'b0;
            active_q    <= 1'b0;
            buzz_q      <= 1'b0;
        end else begin
            tone_cnt_q  <= tone_cnt_d;
            cad_cnt_q   <= cad_cnt_d;
            off_phase_q <= off_phase_d;
            active_q    <= active_d;
            buzz_q      <= buzz_d;
        end
    end

    assign buzz = buzz_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm sequencing controller: compares time of day with the alarm time and
// runs the ring / snooze / stop state machine that drives the buzzer.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int TONE_DIV       = 25_000,
    parameter int CADENCE_DIV    = 25_000_000,
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_S       = 300,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic [HR_W-1:0]  cur_hr,
    input  logic [MIN_W-1:0] cur_min,
    input  logic [HR_W-1:0]  alarm_hr,
    input  logic [MIN_W-1:0] alarm_min,
    input  logic             alarm_en,
    input  logic             btn_snooze,
    input  logic             btn_stop,
    output logic             buzz,
    output logic             ringing,
    output logic             snoozing,
    output logic [1:0]       state
);

    localparam int RW = cnt_w(RING_TIMEOUT_S);
    localparam int SW = cnt_w(SNOOZE_S);
    localparam int NW = cnt_w(MAX_SNOOZE);
    localparam logic [RW-1:0] RING_LIM  = RW'(RING_TIMEOUT_S);
    localparam logic [SW-1:0] SNZ_LIM   = SW'(SNOOZE_S);
    localparam logic [NW-1:0] SNZ_MAX   = NW'(MAX_SNOOZE);

    alarm_state_e  state_q, state_d;
    logic          match_seen_q, match_seen_d;
    logic [RW-1:0] ring_sec_q, ring_sec_d, ring_sec_inc;
    logic [SW-1:0] snz_sec_q, snz_sec_d, snz_sec_inc;
    logic [NW-1:0] snooze_cnt_q, snooze_cnt_d;
    logic          ringing_q, ringing_d;
    logic          snoozing_q, snoozing_d;
    logic          match;

    always_comb begin
        match = (cur_hr == alarm_hr) && (cur_min == alarm_min);

        // Seconds counters saturate at their limit.
        ring_sec_inc = (tick_1hz && ring_sec_q != RING_LIM) ? ring_sec_q + 1'b1 : ring_sec_q;
        snz_sec_inc  = (tick_1hz && snz_sec_q != SNZ_LIM)   ? snz_sec_q + 1'b1  : snz_sec_q;

        state_d      = state_q;
        ring_sec_d   = ring_sec_q;
        snz_sec_d    = snz_sec_q;
        snooze_cnt_d = snooze_cnt_q;
        match_seen_d = match ? match_seen_q : 1'b0;

        if (!alarm_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (tick_1hz && match && !match_seen_q) begin
                        state_d      = ST_RINGING;
                        ring_sec_d   = '0;
                        snooze_cnt_d = '0;
                        match_seen_d = 1'b1;
                    end
                end
                ST_RINGING: begin
                    ring_sec_d = ring_sec_inc;
                    if (btn_stop) begin
                        state_d = ST_ARMED;
                    end else if (ring_sec_inc == RING_LIM) begin
                        state_d = ST_ARMED;
                    end else if (btn_snooze && snooze_cnt_q < SNZ_MAX) begin
                        state_d      = ST_SNOOZE;
                        snooze_cnt_d = snooze_cnt_q + 1'b1;
                        snz_sec_d    = '0;
                    end
                end
                ST_SNOOZE: begin
                    snz_sec_d = snz_sec_inc;
                    if (btn_stop) begin
                        state_d = ST_ARMED;
                    end else if (snz_sec_inc == SNZ_LIM) begin
                        state_d      = ST_RINGING;
                        ring_sec_d   = '0;
                        match_seen_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        ringing_d  = (state_d == ST_RINGING);
        snoozing_d = (state_d == ST_SNOOZE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            match_seen_q <= 1'b0;
            ring_sec_q   <= '0;
            snz_sec_q    <= '0;
            snooze_cnt_q <= '0;
            ringing_q    <= 1'b0;
            snoozing_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            match_seen_q <= match_seen_d;
            ring_sec_q   <= ring_sec_d;
            snz_sec_q    <= snz_sec_d;
            snooze_cnt_q <= snooze_cnt_d;
            ringing_q    <= ringing_d;
            snoozing_q   <= snoozing_d;
        end
    end

    // Driven from the next state so the pattern's first buzz lands with the state change.
    buzz_pattern_gen #(
        .TONE_DIV    (TONE_DIV),
        .CADENCE_DIV (CADENCE_DIV)
    ) u_buzz (
        .clk  (clk),
        .rst  (rst),
        .en   (ringing_d),
        .buzz (buzz)
    );

    assign ringing  = ringing_q;
    assign snoozing = snoozing_q;
    assign state    = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: table vectors, hand-written corner sequences, then
// random stimulus checked against a behavioural model.
module tb_alarm_ctrl;

    localparam int TONE = 2;
    localparam int CAD  = 8;
    localparam int TO   = 3;
    localparam int SNZ  = 2;
    localparam int MAXS = 1;

    logic       clk = 1'b0;
    logic       rst, tick_1hz, alarm_en, btn_snooze, btn_stop;
    logic [4:0] cur_hr, alarm_hr;
    logic [5:0] cur_min, alarm_min;
    logic       buzz, ringing, snoozing;
    logic [1:0] state;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    int m_st, m_secs, m_snz, m_age;
    bit m_seen;

    typedef struct {
        bit r, en, tk;
        int hr, mn;
        bit sz, sp;
        int es, eb;
    } vec_t;
    vec_t vtab[$];

    always #5 clk = ~clk;

    alarm_ctrl #(
        .TONE_DIV(TONE), .CADENCE_DIV(CAD), .RING_TIMEOUT_S(TO),
        .SNOOZE_S(SNZ), .MAX_SNOOZE(MAXS)
    ) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
        .cur_hr(cur_hr), .cur_min(cur_min),
        .alarm_hr(alarm_hr), .alarm_min(alarm_min),
        .alarm_en(alarm_en), .btn_snooze(btn_snooze), .btn_stop(btn_stop),
        .buzz(buzz), .ringing(ringing), .snoozing(snoozing), .state(state)
    );

    // Buzzer level 'age' cycles after ring entry: 2*CAD period, tone half-period TONE.
    function automatic int pattern(input int age);
        int p;
        p = age % (2 * CAD);
        return ((p < CAD) && (((p / TONE) % 2) == 0)) ? 1 : 0;
    endfunction

    task automatic model_edge();
        bit match, entering;
        entering = 0;
        if (rst) begin
            m_st = 0; m_seen = 0; m_secs = 0; m_snz = 0; m_age = 0;
        end else begin
            match = (cur_hr == alarm_hr) && (cur_min == alarm_min);
            if (!alarm_en) m_st = 0;
            else begin
                case (m_st)
                    0: m_st = 1;
                    1: if (tick_1hz && match && !m_seen) begin
                           m_st = 2; m_snz = 0; entering = 1;
                       end
                    2: if (btn_stop) m_st = 1;
                       else begin
                           if (tick_1hz) m_secs++;
                           if (m_secs >= TO) m_st = 1;
                           else if (btn_snooze && m_snz < MAXS) begin
                               m_st = 3; m_snz++; m_secs = 0;
                           end
                       end
                    default: if (btn_stop) m_st = 1;
                       else begin
                           if (tick_1hz) m_secs++;
                           if (m_secs >= SNZ) begin m_st = 2; entering = 1; end
                       end
                endcase
            end
            if (entering) begin
                m_seen = 1; m_secs = 0; m_age = 0;
            end else begin
                if (!match) m_seen = 0;
                m_age++;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int es, input int eb);
        vectors++;
        if (state !== 2'(es) || ringing !== (es == 2) || snoozing !== (es == 3) ||
            (eb >= 0 && buzz !== (eb != 0))) begin
            miscompares++;
            $display("FAIL %s: got state=%0d buzz=%b ringing=%b snoozing=%b, expected state=%0d buzz=%0d",
                     name, state, buzz, ringing, snoozing, es, eb);
        end
    endtask

    task automatic apply(input string name, input bit a_rst, input bit a_en, input bit a_tk,
                         input int hr, input int mn, input bit a_sz, input bit a_sp,
                         input int es, input int eb);
        rst = a_rst; alarm_en = a_en; tick_1hz = a_tk;
        cur_hr = 5'(hr); cur_min = 6'(mn);
        btn_snooze = a_sz; btn_stop = a_sp;
        step();
        chk(name, es, eb);
    endtask

    task automatic add(input bit r, input bit en, input bit tk, input int hr, input int mn,
                       input bit sz, input bit sp, input int es, input int eb);
        vec_t v;
        v = '{r, en, tk, hr, mn, sz, sp, es, eb};
        vtab.push_back(v);
    endtask

    // Hit the alarm minute cleanly: leave the minute, then tick at 07:30.
    task automatic ring_again(input string name);
        apply({name, "_leave"}, 0, 1, 1, 7, 31, 0, 0, 1, 0);
        apply({name, "_ring"},  0, 1, 1, 7, 30, 0, 0, 2, 1);
    endtask

    initial begin
        rst = 1; tick_1hz = 0; alarm_en = 0; btn_snooze = 0; btn_stop = 0;
        cur_hr = 7; cur_min = 29; alarm_hr = 7; alarm_min = 30;

        // Match scenario and the full buzz cadence
        add(1, 0, 0, 7, 29, 0, 0, 0, 0);
        add(0, 1, 0, 7, 29, 0, 0, 1, 0);
        add(0, 1, 1, 7, 29, 0, 0, 1, 0);
        add(0, 1, 0, 7, 30, 0, 0, 1, 0);
        add(0, 1, 1, 7, 30, 0, 0, 2, 1);
        add(0, 1, 0, 7, 30, 0, 0, 2, 1);
        add(0, 1, 0, 7, 30, 0, 0, 2, 0);
        add(0, 1, 0, 7, 30, 0, 0, 2, 0);
        add(0, 1, 0, 7, 30, 0, 0, 2, 1);
        add(0, 1, 0, 7, 30, 0, 0, 2, 1);
        add(0, 1, 0, 7, 30, 0, 0, 2, 0);
        add(0, 1, 0, 7, 30, 0, 0, 2, 0);
        for (int i = 0; i < 8; i++) add(0, 1, 0, 7, 30, 0, 0, 2, 0);
        add(0, 1, 0, 7, 30, 0, 0, 2, 1);
        add(0, 1, 0, 7, 30, 0, 0, 2, 1);
        add(0, 1, 0, 7, 30, 0, 0, 2, 0);

        foreach (vtab[i])
            apply($sformatf("table[%0d]", i), vtab[i].r, vtab[i].en, vtab[i].tk,
                  vtab[i].hr, vtab[i].mn, vtab[i].sz, vtab[i].sp, vtab[i].es, vtab[i].eb);

        // Timeout, no re-ring within the same minute, re-ring after leaving it
        apply("timeout_t1", 0, 1, 1, 7, 30, 0, 0, 2, -1);
        apply("timeout_t2", 0, 1, 1, 7, 30, 0, 0, 2, -1);
        apply("timeout_t3", 0, 1, 1, 7, 30, 0, 0, 1, 0);
        apply("no_rering1", 0, 1, 1, 7, 30, 0, 0, 1, 0);
        apply("no_rering2", 0, 1, 1, 7, 30, 0, 0, 1, 0);
        ring_again("rering");

        // Snooze, expiry, limit reached, stop
        apply("snooze_press", 0, 1, 0, 7, 30, 1, 0, 3, 0);
        apply("snooze_t1",    0, 1, 1, 7, 30, 0, 0, 3, 0);
        apply("snooze_t2",    0, 1, 1, 7, 30, 0, 0, 2, 1);
        apply("snooze_limit", 0, 1, 0, 7, 30, 1, 0, 2, 1);
        apply("snooze_stop",  0, 1, 0, 7, 30, 0, 1, 1, 0);

        // Collisions
        ring_again("coll1");
        apply("stop_and_snooze", 0, 1, 0, 7, 30, 1, 1, 1, 0);
        ring_again("coll2");
        apply("dis_and_snooze",  0, 0, 0, 7, 30, 1, 0, 0, 0);
        apply("reenable",        0, 1, 0, 7, 30, 0, 0, 1, 0);
        ring_again("coll3");
        apply("coll3_snooze",    0, 1, 0, 7, 30, 1, 0, 3, 0);
        apply("coll3_t1",        0, 1, 1, 7, 30, 0, 0, 3, 0);
        apply("stop_vs_expiry",  0, 1, 1, 7, 30, 0, 1, 1, 0);
        ring_again("coll4");
        apply("coll4_t1",        0, 1, 1, 7, 30, 0, 0, 2, -1);
        apply("coll4_t2",        0, 1, 1, 7, 30, 0, 0, 2, -1);
        apply("timeout_vs_snz",  0, 1, 1, 7, 30, 1, 0, 1, 0);

        // Reset during the on-phase
        ring_again("rstring");
        apply("rstring_on",  0, 1, 0, 7, 30, 0, 0, 2, 1);
        apply("rst_midring", 1, 1, 0, 7, 30, 0, 0, 0, 0);
        apply("after_rst",   0, 1, 0, 7, 30, 0, 0, 1, 0);

        // Random stimulus against the model
        for (int n = 0; n < 4000; n++) begin
            int r;
            rst      = ($urandom_range(0, 99) == 0);
            alarm_en = ($urandom_range(0, 59) != 0);
            tick_1hz = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 9);
            if (r < 7)      begin cur_hr = 7; cur_min = 30; end
            else if (r < 8) begin cur_hr = 7; cur_min = 29; end
            else if (r < 9) begin cur_hr = 7; cur_min = 31; end
            else            begin cur_hr = 8; cur_min = 30; end
            btn_snooze = ($urandom_range(0, 15) == 0);
            btn_stop   = ($urandom_range(0, 15) == 0);
            step();
            chk("random", m_st, (m_st == 2) ? pattern(m_age) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
